// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  fpu_pkg : types and constants shared by the FP multiplier writeback slice
//  Rev 1.0
// ============================================================================
package fpu_pkg;

    localparam int FPU_TAG_W = 5;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    // fflags layout {NV,DZ,OF,UF,NX}
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'b00,
        CSR_SET   = 2'b01,
        CSR_CLEAR = 2'b10
    } csr_op_e;

    typedef struct packed {
        logic [31:0]          data;
        logic [FPU_TAG_W-1:0] tag;
        logic [4:0]           flags;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_wb_if.sv
`default_nettype none
// ============================================================================
//  fp_mul_wb_if : multiplier-result and register-file-write handshake bundle
//  Rev 1.0
// ============================================================================
interface fp_mul_wb_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_fp_z;
    logic [TAG_W-1:0] in_tag;
    logic             in_ovrf;
    logic             in_udrf;
    logic             in_nan;
    logic             in_inf;
    logic             in_zer;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_fp_z, in_tag, in_ovrf, in_udrf, in_nan, in_inf, in_zer,
        output in_ready,
        output out_valid, out_data, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_fp_z, in_tag, in_ovrf, in_udrf, in_nan, in_inf, in_zer,
        input  in_ready,
        input  out_valid, out_data, out_tag,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fp_wb_fifo2.sv
`default_nettype none
// ============================================================================
//  fp_wb_fifo2 : 2-entry valid/ready FIFO of writeback entries, registered head
//  Rev 1.0
// ============================================================================
module fp_wb_fifo2
    import fpu_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      push_i,
    input  wire wb_entry_t entry_i,
    output logic           ready_o,
    output logic           valid_o,
    input  wire logic      pop_i,
    output wb_entry_t      head_o
);
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    wb_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       w_push;
    logic       w_pop;

    // ready depends only on occupancy, never on the downstream ready
    assign ready_o = (count_q != CNT_FULL);
    assign valid_o = (count_q != CNT_EMPTY);
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i && ready_o;
    assign w_pop   = pop_i && valid_o;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= CNT_EMPTY;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fp_mul_wb.sv
`default_nettype none
// ============================================================================
//  fp_mul_wb : FP multiplier writeback stage with sticky fflags and frm CSRs
//  Rev 1.0
// ============================================================================
module fp_mul_wb
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fp_mul_wb_if.slave      bus,
    input  wire logic [2:0] instr_rm,
    output logic      [2:0] r_mode,
    output logic            rm_illegal,
    input  wire logic       csr_we,
    input  wire logic [1:0] csr_op,
    input  wire logic       csr_sel,
    input  wire logic [4:0] csr_wdata,
    output logic      [4:0] fflags,
    output logic      [2:0] frm
);
    if (DEPTH != 2) begin : g_bad_depth
        $error("fp_mul_wb: DEPTH must be 2");
    end
    if (TAG_W != FPU_TAG_W) begin : g_bad_tag
        $error("fp_mul_wb: TAG_W must match fpu_pkg::FPU_TAG_W");
    end

    wb_entry_t  w_in_entry;
    wb_entry_t  w_head;
    logic       w_out_valid;
    logic       w_pop;
    logic [4:0] w_in_flags;
    logic [2:0] w_eff;
    csr_op_e    w_op;
    logic [4:0] fflags_q, fflags_d;
    logic [2:0] frm_q, frm_d;
    logic       unused_exc;

    // inf/zer carry no fflags information for a multiply
    assign unused_exc = &{1'b0, bus.in_inf, bus.in_zer};

    always_comb begin
        w_in_flags        = '0;
        w_in_flags[FF_NV] = bus.in_nan;
        w_in_flags[FF_OF] = bus.in_ovrf;
        w_in_flags[FF_UF] = bus.in_udrf;
        w_in_flags[FF_NX] = bus.in_ovrf | bus.in_udrf;
    end

    assign w_in_entry.data  = bus.in_fp_z;
    assign w_in_entry.tag   = bus.in_tag;
    assign w_in_entry.flags = w_in_flags;

    fp_wb_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.in_valid),
        .entry_i (w_in_entry),
        .ready_o (bus.in_ready),
        .valid_o (w_out_valid),
        .pop_i   (bus.out_ready),
        .head_o  (w_head)
    );

    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_head.data;
    assign bus.out_tag   = w_head.tag;
    assign w_pop         = w_out_valid && bus.out_ready;
    assign w_op          = csr_op_e'(csr_op);

    // CSR op applies first, then the committing entry's flags are OR'd on top
    always_comb begin
        fflags_d = fflags_q;
        frm_d    = frm_q;
        if (csr_we) begin
            if (!csr_sel) begin
                case (w_op)
                    CSR_WRITE: fflags_d = csr_wdata;
                    CSR_SET:   fflags_d = fflags_q | csr_wdata;
                    CSR_CLEAR: fflags_d = fflags_q & ~csr_wdata;
                    default:   fflags_d = fflags_q;
                endcase
            end else begin
                case (w_op)
                    CSR_WRITE: frm_d = csr_wdata[2:0];
                    CSR_SET:   frm_d = frm_q | csr_wdata[2:0];
                    CSR_CLEAR: frm_d = frm_q & ~csr_wdata[2:0];
                    default:   frm_d = frm_q;
                endcase
            end
        end
        if (w_pop) fflags_d = fflags_d | w_head.flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_q <= '0;
            frm_q    <= RNE;
        end else begin
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
        end
    end

    assign fflags     = fflags_q;
    assign frm        = frm_q;
    assign w_eff      = (instr_rm == DYN) ? frm_q : instr_rm;
    assign rm_illegal = (w_eff > RMM);
    assign r_mode     = rm_illegal ? RNE : w_eff;
endmodule
`default_nettype wire

// File: tb/tb_fp_mul_wb.sv
`default_nettype none
// ============================================================================
//  tb_fp_mul_wb : directed self-checking bench for fp_mul_wb
//  Rev 1.0
// ============================================================================
module tb_fp_mul_wb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] instr_rm;
    logic [2:0] r_mode;
    logic       rm_illegal;
    logic       csr_we;
    logic [1:0] csr_op;
    logic       csr_sel;
    logic [4:0] csr_wdata;
    logic [4:0] fflags;
    logic [2:0] frm;

    int n_vec = 0;
    int n_err = 0;

    fp_mul_wb_if #(.TAG_W(5)) bus ();

    fp_mul_wb #(.TAG_W(5), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .instr_rm   (instr_rm),
        .r_mode     (r_mode),
        .rm_illegal (rm_illegal),
        .csr_we     (csr_we),
        .csr_op     (csr_op),
        .csr_sel    (csr_sel),
        .csr_wdata  (csr_wdata),
        .fflags     (fflags),
        .frm        (frm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic sel, input logic [1:0] op, input logic [4:0] wd);
        csr_we = 1'b1; csr_sel = sel; csr_op = op; csr_wdata = wd;
        step();
        csr_we = 1'b0;
    endtask

    task automatic set_in(input logic v, input logic [31:0] z, input logic [4:0] t,
                          input logic nan, input logic ov, input logic ud);
        bus.in_valid = v; bus.in_fp_z = z; bus.in_tag = t;
        bus.in_nan = nan; bus.in_ovrf = ov; bus.in_udrf = ud;
    endtask

    initial begin
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.in_inf = 1'b0; bus.in_zer = 1'b0; bus.out_ready = 1'b0;
        instr_rm = 3'b000; csr_we = 1'b0; csr_op = 2'b00; csr_sel = 1'b0; csr_wdata = 5'd0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  bus.out_data,       32'h0);
        chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
        chk("rst_fflags",    32'(fflags),        32'd0);
        chk("rst_frm",       32'(frm),           32'd0);
        step();
        rst_n = 1'b1;
        step();

        // async reset with one result pending and sticky flags set
        csr(1'b0, 2'b01, 5'b11111);
        set_in(1'b1, 32'hDEADBEEF, 5'd7, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pend_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pend_fflags",    32'(fflags),        32'h1F);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_fflags",    32'(fflags),        32'd0);
        chk("midrst_out_data",  bus.out_data,       32'h0);
        #2 rst_n = 1'b1;
        step();

        // single result, 1-cycle latency
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'h41100000, 5'd3, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("one_out_valid", 32'(bus.out_valid), 32'd1);
        chk("one_out_data",  bus.out_data,       32'h41100000);
        chk("one_out_tag",   32'(bus.out_tag),   32'd3);
        step();
        chk("one_drained", 32'(bus.out_valid), 32'd0);
        chk("one_fflags",  32'(fflags),        32'd0);

        // fill while stalled, then drain in order
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h7FC00000, 5'd1, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b1, 32'h7F800000, 5'd2, 1'b0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready",  32'(bus.in_ready), 32'd0);
        chk("full_fflags",    32'(fflags),       32'd0);
        chk("full_head_data", bus.out_data,      32'h7FC00000);
        step();
        chk("stall_hold_data", bus.out_data, 32'h7FC00000);
        bus.out_ready = 1'b1;
        step();
        chk("drain1_fflags", 32'(fflags),      32'h10);
        chk("drain1_data",   bus.out_data,     32'h7F800000);
        chk("drain1_tag",    32'(bus.out_tag), 32'd2);
        step();
        chk("drain2_fflags", 32'(fflags),         32'h15);
        chk("drain2_empty",  32'(bus.out_valid),  32'd0);

        // CSR write coinciding with a commit keeps the commit's flags
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h00000001, 5'd4, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        csr(1'b0, 2'b00, 5'b00000);
        chk("csr_commit_fflags", 32'(fflags), 32'h03);
        csr(1'b0, 2'b11, 5'b11111);
        chk("op11_ignored", 32'(fflags), 32'h03);
        csr(1'b0, 2'b10, 5'b00001);
        chk("fflags_clear", 32'(fflags), 32'h02);
        csr(1'b0, 2'b01, 5'b10000);
        chk("fflags_set", 32'(fflags), 32'h12);

        // rounding-mode resolution
        csr(1'b1, 2'b00, 5'b00010);
        instr_rm = 3'b111;
        #1;
        chk("frm_010",       32'(frm),        32'd2);
        chk("dyn_rmode",     32'(r_mode),     32'd2);
        chk("dyn_illegal",   32'(rm_illegal), 32'd0);
        csr(1'b1, 2'b00, 5'b00101);
        chk("dyn101_rmode",   32'(r_mode),     32'd0);
        chk("dyn101_illegal", 32'(rm_illegal), 32'd1);
        instr_rm = 3'b110;
        #1;
        chk("rm110_illegal", 32'(rm_illegal), 32'd1);
        chk("rm110_rmode",   32'(r_mode),     32'd0);
        instr_rm = 3'b100;
        #1;
        chk("rm100_rmode",   32'(r_mode),     32'd4);
        chk("rm100_illegal", 32'(rm_illegal), 32'd0);
        csr(1'b1, 2'b10, 5'b00100);
        chk("frm_clear", 32'(frm), 32'd1);
        instr_rm = 3'b111;
        #1;
        chk("dyn001_rmode", 32'(r_mode), 32'd1);

        // back-to-back streaming
        csr(1'b0, 2'b00, 5'b00000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h3F800000 + 32'(i), 5'(i), 1'b0, 1'b0, 1'b0);
            step();
            chk("stream_valid",    32'(bus.out_valid), 32'd1);
            chk("stream_data",     bus.out_data,       32'h3F800000 + 32'(i));
            chk("stream_tag",      32'(bus.out_tag),   32'(5'(i)));
            chk("stream_in_ready", 32'(bus.in_ready),  32'd1);
        end
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stream_end_empty",  32'(bus.out_valid), 32'd0);
        chk("stream_end_fflags", 32'(fflags),        32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
